// File: rtl/qam_mod_multi.sv
// QAM modulator: maps QPSK/16-QAM/64-QAM symbols to Gray-coded I/Q levels
// and emits SPS passband samples per symbol, I*cos[n] - Q*sin[n].
// Symbols arrive on a valid/ready input. Samples leave on a valid/ready output.
module qam_mod_multi #(
  parameter int SPS    = 4,
  parameter int TRIG_W = 8
) (
  input  logic                         axi_clk,
  input  logic                         axi_rst,
  input  logic [1:0]                   mode,
  input  logic                         sym_valid,
  input  logic [5:0]                   sym_data,
  output logic                         sym_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [TRIG_W+4:0]     out_data,
  output logic                         sym_last,
  output logic                         mode_err
);

  localparam int  OUT_W = TRIG_W + 5;
  localparam int  CW    = $clog2(SPS);
  localparam int  AMP   = 2**(TRIG_W-1) - 1;
  localparam real PI    = 3.14159265358979323846;

  typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;

  // Carrier tables, constant after elaboration
  logic signed [TRIG_W-1:0] cos_lut [SPS];
  logic signed [TRIG_W-1:0] sin_lut [SPS];

  for (genvar g = 0; g < SPS; g++) begin : g_lut
    localparam int C = int'(AMP * $cos(2.0 * PI * g / SPS));
    localparam int S = int'(AMP * $sin(2.0 * PI * g / SPS));
    assign cos_lut[g] = TRIG_W'(C);
    assign sin_lut[g] = TRIG_W'(S);
  end

  state_t                    state_q, state_d;
  logic                      axi_rst_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [3:0]         i_q, i_d, q_q, q_d;
  logic signed [OUT_W-1:0]   data_q, data_d;
  logic                      merr_q, merr_d;

  logic                      accept, xfer, at_last;
  logic [2:0]                i_g, q_g;
  logic signed [3:0]         i_map, q_map, i_sel, q_sel;
  logic [CW-1:0]             n_sel;

  // Gray-coded bits of one axis to a signed amplitude level.
  // Mode 3 is reserved and falls through to the 16-QAM table.
  function automatic logic signed [3:0] lvl(input logic [1:0] m, input logic [2:0] g);
    logic signed [3:0] r;
    r = 4'sd0;
    case (m)
      2'd0: r = g[0] ? 4'sd1 : -4'sd1;
      2'd2: begin
        case (g)
          3'b000:  r = -4'sd7;
          3'b001:  r = -4'sd5;
          3'b011:  r = -4'sd3;
          3'b010:  r = -4'sd1;
          3'b110:  r =  4'sd1;
          3'b111:  r =  4'sd3;
          3'b101:  r =  4'sd5;
          default: r =  4'sd7;
        endcase
      end
      default: begin
        case (g[1:0])
          2'b00:   r = -4'sd3;
          2'b01:   r = -4'sd1;
          2'b11:   r =  4'sd1;
          default: r =  4'sd3;
        endcase
      end
    endcase
    return r;
  endfunction

  assign out_valid = (state_q == RUN);
  assign at_last   = (cnt_q == CW'(SPS-1));
  // Ready only once reset has been low for a full cycle, and only when the
  // current symbol is finished or completing on this edge.
  assign sym_ready = !axi_rst_q && (!out_valid || (out_ready && at_last));
  assign accept    = sym_valid && sym_ready;
  assign xfer      = out_valid && out_ready;
  assign sym_last  = out_valid && at_last;
  assign out_data  = data_q;
  assign mode_err  = merr_q;

  // Split the symbol into per-axis Gray fields according to constellation
  always_comb begin
    i_g = 3'd0;
    q_g = 3'd0;
    case (mode)
      2'd0: begin i_g = {2'b00, sym_data[1]};  q_g = {2'b00, sym_data[0]};  end
      2'd2: begin i_g = sym_data[5:3];         q_g = sym_data[2:0];         end
      default: begin i_g = {1'b0, sym_data[3:2]}; q_g = {1'b0, sym_data[1:0]}; end
    endcase
    i_map = lvl(mode, i_g);
    q_map = lvl(mode, q_g);
  end

  // Next state, counter, levels and the sample to register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    q_d     = q_q;
    merr_d  = merr_q;
    i_sel   = i_q;
    q_sel   = q_q;
    n_sel   = cnt_q;
    data_d  = data_q;
    if (accept) begin
      // New symbol: sample 0 straight from the freshly mapped levels
      state_d = RUN;
      cnt_d   = '0;
      i_d     = i_map;
      q_d     = q_map;
      i_sel   = i_map;
      q_sel   = q_map;
      n_sel   = '0;
      if (mode == 2'd3) merr_d = 1'b1;
    end else if (xfer) begin
      if (at_last) begin
        // Underrun: no follow-on symbol, go idle
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        n_sel   = cnt_q + CW'(1);
      end
    end
    if (accept || (xfer && !at_last))
      data_d = OUT_W'(i_sel) * OUT_W'(cos_lut[n_sel])
             - OUT_W'(q_sel) * OUT_W'(sin_lut[n_sel]);
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge axi_clk) begin
    axi_rst_q <= axi_rst;
    if (axi_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      q_q     <= '0;
      data_q  <= '0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      q_q     <= q_d;
      data_q  <= data_d;
      merr_q  <= merr_d;
    end
  end

endmodule

// File: tb/tb_qam_mod_multi.sv
// Self-checking bench for qam_mod_multi (SPS=4, TRIG_W=8). A transaction
// model queues the expected samples of each accepted symbol; every cycle the
// DUT handshake and outputs are compared against that queue.
module tb_qam_mod_multi;

  localparam int SPS    = 4;
  localparam int TRIG_W = 8;
  localparam int OUT_W  = TRIG_W + 5;

  logic                    axi_clk = 1'b0;
  logic                    axi_rst;
  logic [1:0]              mode;
  logic                    sym_valid;
  logic [5:0]              sym_data;
  logic                    sym_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    sym_last;
  logic                    mode_err;

  qam_mod_multi #(.SPS(SPS), .TRIG_W(TRIG_W)) dut (
    .axi_clk  (axi_clk),
    .axi_rst  (axi_rst),
    .mode     (mode),
    .sym_valid(sym_valid),
    .sym_data (sym_data),
    .sym_ready(sym_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sym_last (sym_last),
    .mode_err (mode_err)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct { int d; bit last; } samp_t;

  samp_t exp_q[$];
  int    obs[$];
  bit    rst_m  = 1'b1;
  bit    merr_m = 1'b0;
  int    n_vec  = 0;
  int    n_err  = 0;

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Amplitude of one axis: Gray field -> binary index -> odd level
  function automatic int axis_lvl(input int g, input int k);
    int b;
    b = g ^ (g >> 1) ^ (g >> 2);
    return 2 * b - ((1 << k) - 1);
  endfunction

  function automatic int ref_samp(input int m, input int d, input int n);
    int  k, msk, il, ql, c, s;
    real ang;
    k   = (m == 0) ? 1 : (m == 2) ? 3 : 2;
    msk = (1 << k) - 1;
    il  = axis_lvl((d >> k) & msk, k);
    ql  = axis_lvl(d & msk, k);
    ang = 2.0 * 3.14159265358979 * n / SPS;
    c   = int'(((1 << (TRIG_W-1)) - 1) * $cos(ang));
    s   = int'(((1 << (TRIG_W-1)) - 1) * $sin(ang));
    return il * c - ql * s;
  endfunction

  // One clock: drive inputs, check outputs at the falling edge, advance model
  task automatic cyc(input bit r, input bit v, input int m, input int d, input bit o);
    bit ev, elast, erdy;
    int seen;
    samp_t e;
    axi_rst = r; sym_valid = v; mode = 2'(m); sym_data = 6'(d); out_ready = o;
    @(negedge axi_clk);
    ev    = exp_q.size() > 0;
    elast = ev && exp_q[0].last;
    erdy  = !rst_m && (!ev || (o && elast));
    chk("out_valid", out_valid, ev);
    chk("sym_ready", sym_ready, erdy);
    chk("mode_err", mode_err, merr_m);
    chk("sym_last", sym_last, elast);
    if (ev) chk("out_data", out_data, exp_q[0].d);
    if (rst_m) chk("rst_out_data", out_data, 0);
    seen = out_data;
    @(posedge axi_clk);
    if (r) begin
      exp_q.delete();
      merr_m = 1'b0;
    end else begin
      if (ev && o) begin
        void'(exp_q.pop_front());
        obs.push_back(seen);
      end
      if (v && erdy) begin
        for (int n = 0; n < SPS; n++) begin
          e.d = ref_samp((m == 3) ? 1 : m, d, n);
          e.last = (n == SPS-1);
          exp_q.push_back(e);
        end
        if (m == 3) merr_m = 1'b1;
      end
    end
    rst_m = r;
    #1;
  endtask

  task automatic chk_obs(input string tag, input int s0, input int s1, input int s2, input int s3);
    int ex[4];
    ex = '{s0, s1, s2, s3};
    chk({tag, "_count"}, obs.size(), 4);
    for (int i = 0; i < 4; i++)
      chk(tag, (i < obs.size()) ? obs[i] : 32'sh7fffffff, ex[i]);
    obs.delete();
  endtask

  // Accept one symbol (assumes output idle) and drain it
  task automatic one_sym(input int m, input int d);
    cyc(0, 1, m, d, 1);
    for (int i = 0; i < SPS; i++) cyc(0, 0, 0, 0, 1);
  endtask

  initial begin
    axi_rst = 1'b1; sym_valid = 1'b0; mode = '0; sym_data = '0; out_ready = 1'b1;
    @(posedge axi_clk); #1;
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 9, 1);

    // first cycle after release: not ready yet
    cyc(0, 1, 1, 9, 1);
    obs.delete();
    for (int i = 0; i < SPS; i++) cyc(0, 0, 0, 0, 1);
    one_sym(1, 9);
    chk_obs("qam16_09", 381, 127, -381, -127);
    one_sym(0, 2);
    chk_obs("qpsk_2", 127, 127, -127, -127);
    one_sym(2, 32);
    chk_obs("qam64_20", 889, 889, -889, -889);

    // back-to-back: sym_valid held through the second accept
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 9, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    chk("b2b_count", obs.size(), 8);
    obs.delete();

    // stall three cycles on sample n=1
    cyc(0, 1, 1, 9, 1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 9, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk_obs("stall", 381, 127, -381, -127);

    // reserved mode behaves as 16-QAM and latches mode_err
    one_sym(3, 9);
    chk_obs("mode3", 381, 127, -381, -127);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

    // reset after the second sample
    cyc(0, 1, 1, 9, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 1, 2, 32, 1);
    one_sym(2, 32);
    chk("rst_pre", obs.size(), 6);
    chk("rst_post0", (obs.size() == 6) ? obs[2] : 0, 889);
    obs.delete();

    // random traffic with occasional stalls and resets
    for (int i = 0; i < 2000; i++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 3), $urandom_range(0, 63), ($urandom_range(0, 4) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qam_mod_multi.md
QAM_MOD_MULTI -- requirements
Module: qam_mod_multi

Interface
REQ-001 SHALL have parameter: SPS, 4, samples per symbol; power of 2, 4..64.
REQ-002 SHALL have parameter: TRIG_W, 8, signed carrier LUT width; 6..12.
REQ-003 SHALL have localparam: OUT_W = TRIG_W+5.
REQ-004 SHALL have port: axi_clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: axi_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port: mode  in  2  constellation: 0=QPSK, 1=16-QAM, 2=64-QAM, 3=reserved.
REQ-007 SHALL have port: sym_valid  in  1  input symbol valid.
REQ-008 SHALL have port: sym_data  in  6  symbol bits, LSB-aligned (QPSK [1:0], 16-QAM [3:0], 64-QAM [5:0]).
REQ-009 SHALL have port: sym_ready  out  1  symbol accept.
REQ-010 SHALL have port: out_valid  out  1  sample valid.
REQ-011 SHALL have port: out_ready  in  1  downstream accept.
REQ-012 SHALL have port: out_data  out  OUT_W  signed passband sample.
REQ-013 SHALL have port: sym_last  out  1  high with the final sample of each symbol.
REQ-014 SHALL have port: mode_err  out  1  sticky flag, reserved mode seen.

Function
REQ-015 Symbol accept SHALL be sym_valid && sym_ready; sample transfer SHALL be out_valid && out_ready.
REQ-016 sym_ready SHALL equal !axi_rst_q && (!out_valid || (out_ready && cnt==SPS-1)), where axi_rst_q is axi_rst registered; sym_ready is combinational.
REQ-017 mode SHALL be sampled only on symbol accept and held for all SPS samples of that symbol.
REQ-018 Mode 3 SHALL be treated as 16-QAM and SHALL set mode_err on the accepting edge; mode_err clears only on reset.
REQ-019 Per-axis Gray map, QPSK: I=sym_data[1], Q=sym_data[0]; 0->-1, 1->+1.
REQ-020 16-QAM: I=[3:2], Q=[1:0]; 00->-3, 01->-1, 11->+1, 10->+3.
REQ-021 64-QAM: I=[5:3], Q=[2:0]; 000->-7, 001->-5, 011->-3, 010->-1, 110->+1, 111->+3, 101->+5, 100->+7.
REQ-022 Mapped levels SHALL be held as 4-bit signed registers.
REQ-023 Carrier LUT SHALL be fixed at elaboration: cos[n]=round(A*cos(2*pi*n/SPS)), sin[n]=round(A*sin(2*pi*n/SPS)), A=2^(TRIG_W-1)-1.
REQ-024 Sample n SHALL be out_data = I*cos[n] - Q*sin[n]; full precision, no rounding or saturation.
REQ-025 Sample index cnt (log2(SPS) bits) SHALL be 0 for the first sample of every symbol; carrier phase is continuous across back-to-back symbols.
REQ-026 Latency: symbol accepted at edge k -> out_valid=1 with sample n=0 after edge k.
REQ-027 out_data, sym_last and cnt SHALL hold while out_valid && !out_ready.
REQ-028 Each transfer with cnt<SPS-1 SHALL advance cnt by 1 and register the next sample.
REQ-029 Transfer at cnt==SPS-1 with a simultaneous symbol accept SHALL load the new symbol's n=0 sample; no idle cycle.
REQ-030 Transfer at cnt==SPS-1 with no symbol accept SHALL clear out_valid and cnt (underrun, output idle).
REQ-031 sym_last SHALL be out_valid && cnt==SPS-1.
REQ-032 Two states: IDLE (out_valid=0) and RUN (out_valid=1); IDLE->RUN on accept, RUN->IDLE per REQ-030, RUN->RUN otherwise.

Reset
REQ-033 While axi_rst=1 at a clock edge: out_valid, out_data, sym_last, mode_err, cnt, I and Q SHALL be 0; state SHALL be IDLE.
REQ-034 sym_ready SHALL be 0 while axi_rst=1 and during the first cycle after reset release; it follows REQ-016 from the second cycle.
REQ-035 Reset mid-symbol SHALL discard the remaining samples; no sample of that symbol appears after release.

Verification (SPS=4, TRIG_W=8: cos=127,0,-127,0; sin=0,127,0,-127)
REQ-036 mode=1, sym_data=0x09, out_ready=1 -> out_data 381,127,-381,-127; sym_last on the 4th sample.
REQ-037 mode=0, sym_data=0x2 -> 127,127,-127,-127; mode=2, sym_data=0x20 -> 889,889,-889,-889.
REQ-038 Two 16-QAM symbols back-to-back with sym_valid held -> 8 consecutive out_valid cycles, sym_ready high only on the 4th and 8th samples.
REQ-039 out_ready low 3 cycles at sample n=1 -> out_data held at 127; sym_ready 0; sequence then resumes unchanged.
REQ-040 mode=3, sym_data=0x09 -> same samples as REQ-036; mode_err=1 until axi_rst is asserted.
REQ-041 axi_rst pulsed after the 2nd sample -> all outputs 0; sym_ready 0 for one cycle after release; the next symbol starts at n=0.
